// File: rtl/direction_queue.sv
// Turns debounced button levels into direction commands, buffers up to DEPTH of
// them between game ticks, and commits one direction to the game core per tick.
module direction_queue #(
    parameter int DEPTH = 2,
    parameter logic [1:0] INIT_DIR = 2'b11
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       ButtonLeft,
    input  logic       ButtonRight,
    input  logic       ButtonUp,
    input  logic       ButtonDown,
    input  logic       Tick,
    input  logic       Enable,
    input  logic       Clear,
    output logic [1:0] Dir,
    output logic [2:0] Count,
    output logic       Stepped,
    output logic       Dropped
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    logic [1:0]    queueMem [DEPTH];
    logic [PW-1:0] rdPtr;
    logic [PW-1:0] wrPtr;
    logic [PW-1:0] tailIdx;
    logic [3:0]    prevLevel;
    logic [3:0]    curLevel;
    logic [3:0]    rise;
    logic          candValid;
    logic [1:0]    candDir;
    logic [1:0]    refDir;
    logic          pressOk;
    logic          doPop;
    logic          doPush;
    logic          isFull;
    logic          dropNow;

    function automatic logic [PW-1:0] ptrNext(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign curLevel = {ButtonLeft, ButtonRight, ButtonUp, ButtonDown};
    assign rise     = curLevel & ~prevLevel;

    always_comb begin
        candValid = 1'b1;
        candDir   = DIR_UP;
        if (rise[3])      candDir = DIR_LEFT;
        else if (rise[2]) candDir = DIR_RIGHT;
        else if (rise[1]) candDir = DIR_UP;
        else if (rise[0]) candDir = DIR_DOWN;
        else              candValid = 1'b0;
    end

    // Directions on the same axis (equal or opposite) share bit 1, so one compare rejects both.
    assign tailIdx = (wrPtr == '0) ? PW'(DEPTH - 1) : wrPtr - PW'(1);
    assign refDir  = (Count != 3'd0) ? queueMem[tailIdx] : Dir;
    assign pressOk = candValid && (candDir[1] != refDir[1]);

    assign doPop   = Tick && Enable && (Count != 3'd0);
    assign isFull  = (Count == 3'(DEPTH));
    assign doPush  = pressOk && (!isFull || doPop);
    assign dropNow = pressOk && isFull && !doPop;

    always_ff @(posedge Clock) begin
        if (Reset || Clear) begin
            Dir       <= INIT_DIR;
            Count     <= 3'd0;
            Stepped   <= 1'b0;
            Dropped   <= 1'b0;
            rdPtr     <= '0;
            wrPtr     <= '0;
            prevLevel <= curLevel;
        end else begin
            prevLevel <= curLevel;
            Stepped   <= Tick && Enable;
            Dropped   <= dropNow;
            if (doPop) begin
                Dir   <= queueMem[rdPtr];
                rdPtr <= ptrNext(rdPtr);
            end
            if (doPush) begin
                wrPtr <= ptrNext(wrPtr);
            end
            if (doPush && !doPop)      Count <= Count + 3'd1;
            else if (doPop && !doPush) Count <= Count - 3'd1;
        end
    end

    // Entry contents need no reset: Count gates every read of the storage.
    always_ff @(posedge Clock) begin
        if (!Reset && !Clear && doPush) begin
            queueMem[wrPtr] <= candDir;
        end
    end

endmodule

// File: doc/direction_queue.md
Name: direction_queue

Overview:
- Sits between the five button debouncers and the game core.
- Converts debounced button levels into direction commands and buffers them between game ticks, so that two quick turns (e.g. Up then Left) inside one game step are both honoured.
- Filters out reversals and repeated directions.
- Presents the game core with one committed direction per game tick.

Parameters:
DEPTH, 2, number of buffered direction commands (1..4)
INIT_DIR, 2'b11, direction after reset or Clear (RIGHT)

Ports:
Clock  input  1  system clock (debouncer-rate clock domain)
Reset  input  1  synchronous, active-high reset
ButtonLeft  input  1  debounced level, high while pressed
ButtonRight  input  1  debounced level
ButtonUp  input  1  debounced level
ButtonDown  input  1  debounced level
Tick  input  1  one-cycle pulse, game step request
Enable  input  1  low = paused; Tick ignored
Clear  input  1  one-cycle pulse, game restart
Dir  output  2  committed direction: 00 UP, 01 DOWN, 10 LEFT, 11 RIGHT
Count  output  3  entries currently queued (0..DEPTH)
Stepped  output  1  one-cycle pulse, registered, high the cycle after an accepted Tick
Dropped  output  1  one-cycle pulse, a valid press was lost because the queue was full

Behaviour:
- Reset and Clear (identical effect; Reset has priority, Clear overrides every other event in the same cycle):
  - Dir=INIT_DIR, Count=0, Stepped=0, Dropped=0.
  - Queue storage is invalidated.
  - Edge-detect history registers are loaded with the current button levels, so a button held through reset does not generate a press.
- Press detection:
  - A press is a rising edge of a button level, comparing the current level against a registered copy from the previous cycle.
  - A held button generates exactly one press.
  - Several rising edges in one cycle: only one is taken, with priority Left > Right > Up > Down. The others are discarded.
- Validation:
  - The reference direction is the newest queued entry if Count>0, otherwise Dir.
  - The candidate is rejected silently (no Dropped) if it equals the reference or is its opposite (UP/DOWN, LEFT/RIGHT).
- Push:
  - A valid candidate is written at the queue tail and Count increments.
  - If Count==DEPTH and no pop occurs that cycle, the candidate is discarded and Dropped=1 for one cycle.
- Pop:
  - Occurs when Tick=1, Enable=1 and Count>0.
  - Dir <= queue head on the next edge; Count decrements.
  - Tick with Count==0: Dir holds.
  - Stepped=1 the cycle after any Tick with Enable=1, whether or not a pop happened.
- Simultaneous pop and push:
  - Both take effect in the same cycle, and Count is unchanged.
  - When full, the pop frees a slot, so the push succeeds and Dropped=0.
  - Validation still uses the pre-pop reference. This is consistent because a popped last entry becomes Dir.
- Tick with Enable=0: no pop, no Stepped. Presses are still accepted and queued while paused.
- Storage: circular buffer with read and write pointers of clog2(DEPTH) bits that wrap at DEPTH, not at the power of two.
- Dir changes only on pop, Reset or Clear.
- All outputs are registered. Latency:
  - Tick to Dir: 1 cycle.
  - Press edge to Count increment: 1 cycle after the level rises.

Test Plan:
- Reset with ButtonUp held high, then release and re-press -> Dir=2'b11 and Count=0 after reset; exactly one entry (UP) queued, and only on the re-press.
- Dir=RIGHT, press LEFT, then Tick -> press rejected, Count stays 0; after Tick Dir=2'b11, Stepped=1 for one cycle.
- Dir=RIGHT, press UP, then LEFT, then Tick, Tick -> Count=2; Dir=00 after the first Tick; Dir=10 after the second Tick, with Count=0.
- DEPTH=2, Dir=RIGHT, queue holds UP,LEFT; press DOWN -> Dropped=1 and Count stays 2. Repeat the full-queue case with the press coincident with Tick -> Dropped=0, Count=2, Dir=00.
- Enable=0, Tick pulsed with UP queued -> Dir unchanged, Stepped=0, Count=1. Then Enable=1 and Tick -> Dir=00.
- Left and Up rising in the same cycle from Dir=DOWN -> only LEFT queued, Count=1. Then Clear with Count=1 and a Tick in the same cycle -> Dir=2'b11, Count=0, Stepped=0.
